// File: rtl/g_logic_sliced.sv
// rtl/g_logic_sliced.sv - sliced multi-op bitwise logic unit with valid/ready handshake
// Optional back-to-back accept in DONE: define G_LOGIC_SLICED_B2B_EN.
module g_logic_sliced #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  input  logic [2:0]       Op,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] Out,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             Busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_next, full_res;
  logic [2:0]       op_q;
  logic [IDX_W-1:0] idx;
  logic             accept;

  assign accept = InValid && InReady;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = CALC;
      CALC: if (idx == LAST_IDX) next_state = DONE;
      DONE: begin
        if (OutReady) begin
`ifdef G_LOGIC_SLICED_B2B_EN
          next_state = InValid ? CALC : IDLE;
`else
          next_state = IDLE;
`endif
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    InReady  = (state == IDLE);
    OutValid = (state == DONE);
    Busy     = (state != IDLE);
`ifdef G_LOGIC_SLICED_B2B_EN
    if (state == DONE) InReady = OutReady;
`endif
  end

  // Bitwise ops are per-bit, so the full-width result is computed once and
  // only the slice selected by idx is committed each CALC cycle.
  always_comb begin
    full_res = '0;
    case (op_q)
      3'b000: full_res = ~a_q;
      3'b001: full_res = a_q & b_q;
      3'b010: full_res = a_q | b_q;
      3'b011: full_res = a_q ^ b_q;
      3'b100: full_res = ~(a_q & b_q);
      3'b101: full_res = ~(a_q | b_q);
      3'b110: full_res = ~(a_q ^ b_q);
      default: full_res = a_q;
    endcase
  end

  always_comb begin
    res_next = res_q;
    for (int s = 0; s < NSLICE; s++) begin
      if (idx == IDX_W'(s)) res_next[s*SLICE +: SLICE] = full_res[s*SLICE +: SLICE];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      res_q <= '0;
      idx   <= '0;
    end else if (accept) begin
      a_q   <= InA;
      b_q   <= InB;
      op_q  <= Op;
      res_q <= '0;
      idx   <= '0;
    end else if (state == CALC) begin
      res_q <= res_next;
      idx   <= idx + IDX_W'(1);
    end
  end

  assign Out = res_q & {WIDTH{OutValid}};

endmodule

// File: doc/g_logic_sliced.md
Name: g_logic_sliced

Overview:
Parametrised multi-op bitwise logic unit, successor to the fixed 32-bit gated NOT/AND/OR gates of the ALU32 gate library.
- Captures two WIDTH-bit operands and an op code through a valid/ready handshake.
- Evaluates the result SLICE bits per cycle under a small FSM, then holds it until downstream accepts.
- Sits between the ALU operand registers and the ALU result mux; the output is forced to zero whenever not valid, which generalises the old Enable gating.

Parameters:
WIDTH, 32, operand/result width in bits; must be an integer multiple of SLICE.
SLICE, 8, bits evaluated per CALC cycle; NSLICE = WIDTH/SLICE (1 legal).

Ports:
Clk  input  1  clock; all state updates on rising edge.
Reset  input  1  synchronous, active-high reset.
InA  input  WIDTH  operand A.
InB  input  WIDTH  operand B (ignored for unary ops).
Op  input  3  operation select, sampled at accept.
InValid  input  1  upstream presents InA/InB/Op.
InReady  output  1  block can accept.
Out  output  WIDTH  result; all zeros while OutValid=0.
OutValid  output  1  result available.
OutReady  input  1  downstream accepts result.
Busy  output  1  high in any state other than IDLE.

Behaviour:
- Clocking/reset: one clock (Clk); Reset synchronous active-high.
- Reset values: state=IDLE, operand/op registers=0, result register=0, slice index=0, Out=0, OutValid=0, InReady=1, Busy=0.
- Op encoding: 000 NOT A; 001 A AND B; 010 A OR B; 011 A XOR B; 100 NAND; 101 NOR; 110 XNOR; 111 PASS A. All codes are legal.
- IDLE: InReady=1. On InValid&&InReady at an edge, capture InA, InB and Op, clear the slice index and result, then go to CALC.
- CALC: InReady=0.
  - Each edge computes slice[idx] = f(A[idx*SLICE +: SLICE], B[...]), writes it into the result register, and increments idx.
  - When idx==NSLICE-1 at an edge, go to DONE.
- DONE: OutValid=1, Out=result register, InReady=0.
  - On an OutReady edge, go to IDLE, clear OutValid, and zero Out.
  - If OutReady is low, hold Out and OutValid indefinitely.
- Latency: the accept edge is E0. OutValid rises after edge E0+NSLICE. A result occupies NSLICE+1 cycles minimum; with NSLICE=1 the result is valid after E0+1.
- Input isolation: InA, InB and Op changes after E0 do not affect the in-flight result.
- Handshake rules:
  - InValid while not IDLE is ignored and is not queued.
  - The upstream must hold InValid until InReady is seen.
  - OutReady outside DONE is ignored.
- Out gating: Out is combinationally ANDed with OutValid, so Out never shows partial results.
- Reset mid-operation (CALC or DONE): the next edge returns all state to reset values and the in-flight result is discarded.
- Reset with InValid high: no capture occurs on that edge.

Optional Feature:
Macro G_LOGIC_SLICED_B2B_EN.
- Defined:
  - In DONE, InReady = OutReady.
  - At an edge with OutReady&&InValid, the result is consumed and the new operands are captured in the same edge, going directly to CALC with no IDLE bubble.
  - OutValid drops for the NSLICE CALC cycles.
  - Throughput is one result per NSLICE+1 cycles.
- Undefined:
  - InReady=0 in DONE.
  - There is always at least one IDLE cycle between results, so minimum spacing is NSLICE+2 cycles.

Test Plan:
1. Reset held 2 cycles, then released (WIDTH=32, SLICE=8) -> Out=0x00000000, OutValid=0, InReady=1, Busy=0.
2. Op=000, InA=0x0F0F00FF accepted at E0, OutReady=1 -> OutValid rises after E0+4, Out=0xF0F0FF00 for one cycle, then IDLE.
3. Op=011, InA=0xFFFF0000, InB=0x0F0F0F0F, OutReady low 10 cycles -> Out stays 0xF0F00F0F, OutValid=1, InReady=0 throughout; InA changed to 0x12345678 during CALC has no effect.
4. Op=100 accepted, Reset pulsed one cycle after the 2nd CALC edge -> next cycle IDLE, Out=0, OutValid=0; then Op=101, A=0x00FF00FF, B=0x0000FFFF -> Out=0xFF000000.
5. SLICE=32 (NSLICE=1), Op=110, A=B=0xA5A5A5A5 -> OutValid after E0+1, Out=0xFFFFFFFF.
6. Two back-to-back ops with InValid held high and OutReady=1:
   - With G_LOGIC_SLICED_B2B_EN: second accept on the same edge the first result is consumed, results 5 cycles apart.
   - Without it: one IDLE cycle between, results 6 cycles apart.
